// File: rtl/layer2_filter_loader.sv
// Write-side controller for the layer-2 filter buffer: fetches one 16-word
// 4x4x4 filter from synchronous memory, writes it to the buffer, then exposes it.
module layer2_filter_loader #(
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              consume,
  output logic              mem_re,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [31:0]       mem_rdata,
  output logic              buf_we,
  output logic [1:0]        buf_i,
  output logic [1:0]        buf_depth,
  output logic [31:0]       buf_data,
  output logic              buf_re,
  output logic              busy,
  output logic              done
);

  localparam int unsigned K_W    = 4;
  localparam int unsigned DATA_W = 32;
  localparam logic [K_W-1:0] K_LAST = K_W'(15);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DRAIN,
    S_READY
  } state_e;

  state_e              state_q, state_d;
  logic [K_W-1:0]      k_q, k_d;
  logic                mem_re_q, mem_re_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                pend_q;
  logic [K_W-1:0]      pend_k_q;
  logic                buf_we_q;
  logic [K_W-1:0]      buf_k_q;
  logic [DATA_W-1:0]   buf_data_q;
  logic                buf_re_q, busy_q, done_q;

  // Next-state and read-issue logic; start has priority over consume in READY.
  always_comb begin
    state_d    = state_q;
    k_d        = k_q;
    mem_re_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    case (state_q)
      S_IDLE, S_READY: begin
        if (start) begin
          state_d    = S_FETCH;
          k_d        = '0;
          mem_re_d   = 1'b1;
          mem_addr_d = base_addr;
        end else if (state_q == S_READY && consume) begin
          state_d = S_IDLE;
        end
      end
      S_FETCH: begin
        if (k_q == K_LAST) begin
          state_d = S_DRAIN;
        end else begin
          k_d        = k_q + K_W'(1);
          mem_re_d   = 1'b1;
          mem_addr_d = mem_addr_q + ADDR_W'(1);
        end
      end
      S_DRAIN: begin
        if (buf_we_q && buf_k_q == K_LAST) state_d = S_READY;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      k_q        <= '0;
      mem_re_q   <= 1'b0;
      mem_addr_q <= '0;
      buf_re_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      k_q        <= k_d;
      mem_re_q   <= mem_re_d;
      mem_addr_q <= mem_addr_d;
      buf_re_q   <= (state_d == S_READY);
      busy_q     <= (state_d == S_FETCH) || (state_d == S_DRAIN);
      done_q     <= (state_d == S_READY) && (state_q != S_READY);
    end
  end

  // Read-data pipeline: pend marks the cycle memory data is valid, then it is registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q     <= 1'b0;
      pend_k_q   <= '0;
      buf_we_q   <= 1'b0;
      buf_k_q    <= '0;
      buf_data_q <= '0;
    end else begin
      pend_q   <= mem_re_q;
      pend_k_q <= k_q;
      buf_we_q <= pend_q;
      if (pend_q) begin
        buf_data_q <= mem_rdata;
        buf_k_q    <= pend_k_q;
      end
    end
  end

  assign mem_re    = mem_re_q;
  assign mem_addr  = mem_addr_q;
  assign buf_we    = buf_we_q;
  assign buf_i     = buf_k_q[1:0];
  assign buf_depth = buf_k_q[3:2];
  assign buf_data  = buf_data_q;
  assign buf_re    = buf_re_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_layer2_filter_loader.sv
// Self-checking bench for layer2_filter_loader: memory model plus a cycle
// timeline reference derived from the load schedule.
module tb_layer2_filter_loader;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [7:0]  base_addr;
  logic        consume;
  logic        mem_re;
  logic [7:0]  mem_addr;
  logic [31:0] mem_rdata;
  logic        buf_we;
  logic [1:0]  buf_i;
  logic [1:0]  buf_depth;
  logic [31:0] buf_data;
  logic        buf_re;
  logic        busy;
  logic        done;

  int total = 0;
  int bad = 0;
  int rd_cnt = 0;

  logic [31:0] mem [256];
  logic [31:0] fbuf [16];

  layer2_filter_loader #(.ADDR_W(8)) dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .consume(consume),
    .mem_re(mem_re), .mem_addr(mem_addr), .mem_rdata(mem_rdata),
    .buf_we(buf_we), .buf_i(buf_i), .buf_depth(buf_depth), .buf_data(buf_data),
    .buf_re(buf_re), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  // Synchronous filter memory, read-count monitor and filter buffer model.
  always @(posedge clk) begin
    if (mem_re) begin
      mem_rdata <= mem[mem_addr];
      rd_cnt    <= rd_cnt + 1;
    end
    if (buf_we) fbuf[{buf_depth, buf_i}] <= buf_data;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full load; expectations come from the cycle schedule (start sampled at edge 0).
  task automatic load_check(input logic [7:0] base, input bit dup, input bit with_cons);
    int reads0;
    int k;
    @(negedge clk);
    start = 1'b1; base_addr = base; consume = with_cons;
    reads0 = rd_cnt;
    for (int c = 1; c <= 21; c++) begin
      @(negedge clk);
      if (c == 1) begin start = 1'b0; consume = 1'b0; base_addr = 8'hAA; end
      if (dup && c == 5) begin start = 1'b1; base_addr = 8'h77; end
      if (dup && c == 6) start = 1'b0;
      chk("mem_re", 32'(mem_re), 32'(c <= 16));
      if (c <= 16) chk("mem_addr", 32'(mem_addr), 32'(8'(base + 8'(c - 1))));
      chk("buf_we", 32'(buf_we), 32'(c >= 3 && c <= 18));
      if (c >= 3 && c <= 18) begin
        k = c - 3;
        chk("buf_data", buf_data, mem[8'(base + 8'(k))]);
        chk("buf_depth", 32'(buf_depth), 32'(k / 4));
        chk("buf_i", 32'(buf_i), 32'(k % 4));
      end
      if (c == 19) chk("buf_data_hold", buf_data, mem[8'(base + 8'd15)]);
      chk("busy", 32'(busy), 32'(c <= 18));
      chk("done", 32'(done), 32'(c == 19));
      chk("buf_re", 32'(buf_re), 32'(c >= 19));
    end
    chk("read_count", 32'(rd_cnt - reads0), 32'd16);
    for (int w = 0; w < 16; w++)
      chk("filter_word", fbuf[w], mem[8'(base + 8'(w))]);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; base_addr = '0; consume = 1'b0; mem_rdata = '0;
    for (int n = 0; n < 256; n++) mem[n] = {4{8'(n)}};
    #1;
    chk("rst_mem_re", 32'(mem_re), 32'd0);
    chk("rst_buf_we", 32'(buf_we), 32'd0);
    chk("rst_buf_data", buf_data, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_buf_re", 32'(buf_re), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Consume while idle has no effect.
    @(negedge clk); consume = 1'b1;
    @(negedge clk); consume = 1'b0;
    chk("idle_consume_re", 32'(buf_re), 32'd0);
    chk("idle_consume_busy", 32'(busy), 32'd0);

    load_check(8'h10, 1'b0, 1'b0);
    chk("first_col0", 32'(fbuf[0][31:24]), 32'h10);
    chk("last_col3", 32'(fbuf[15][7:0]), 32'h1F);

    // Consume releases READY.
    @(negedge clk); consume = 1'b1;
    @(negedge clk); consume = 1'b0;
    chk("consume_buf_re", 32'(buf_re), 32'd0);
    chk("consume_busy", 32'(busy), 32'd0);
    chk("consume_done", 32'(done), 32'd0);
    @(negedge clk);
    chk("idle_mem_re", 32'(mem_re), 32'd0);
    chk("idle_buf_re", 32'(buf_re), 32'd0);

    for (int n = 0; n < 256; n++) mem[n] = $urandom;
    load_check(8'hF8, 1'b1, 1'b0);
    load_check(8'h40, 1'b0, 1'b1);
    load_check(8'($urandom_range(0, 255)), 1'b1, 1'b0);

    // Asynchronous reset in the middle of a fetch.
    @(negedge clk); start = 1'b1; base_addr = 8'($urandom_range(0, 255));
    @(negedge clk); start = 1'b0;
    repeat (6) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("arst_mem_re", 32'(mem_re), 32'd0);
    chk("arst_buf_we", 32'(buf_we), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_buf_re", 32'(buf_re), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    chk("post_rst_busy", 32'(busy), 32'd0);
    load_check(8'($urandom_range(0, 255)), 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/layer2_filter_loader.md
Name: layer2_filter_loader

Overview:
- Write-side controller for the layer-2 filter buffer.
- On `start`, fetches one 4x4x4 filter (16 x 32-bit words, 4 bytes per row) from a synchronous filter memory and drives the buffer's write port (`we`, `i`, `depth_index`, `datain`).
- After the last write, holds the buffer's `re` high so the 512-bit filter is visible to the layer-2 convolution datapath, until that datapath signals `consume`.

Parameters:
- ADDR_W, 8, width of filter memory word address.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  begin loading one filter; sampled in IDLE or READY.
- base_addr  input  ADDR_W  word address of filter word 0; captured when start is accepted.
- consume  input  1  datapath finished with the current filter; releases READY.
- mem_re  output  1  filter memory read enable.
- mem_addr  output  ADDR_W  filter memory word address.
- mem_rdata  input  32  memory read data; valid exactly 1 cycle after the mem_re cycle.
- buf_we  output  1  to buffer `we`.
- buf_i  output  2  to buffer `i` (row index).
- buf_depth  output  2  to buffer `depth_index`.
- buf_data  output  32  to buffer `datain`; byte [31:24] is column 0.
- buf_re  output  1  to buffer `re`; high only in READY.
- busy  output  1  high in FETCH and DRAIN.
- done  output  1  one-cycle pulse on the first cycle of READY.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; word counters 0. Partially written buffer contents are don't-care.
- States:
  - IDLE: waits for start.
  - FETCH: issues 16 reads.
  - DRAIN: writes the last 2 in-flight words.
  - READY: buf_re=1, filter exposed.
- Word order: k = 0..15; depth = k[3:2], row = k[1:0]; mem_addr = base_addr + k, modulo 2^ADDR_W (wraps silently).
- Timing, with start sampled at edge 0:
  - FETCH occupies cycles 1..16, with mem_re=1 and mem_addr=base+k in cycle k+1.
  - mem_rdata for word k arrives in cycle k+2.
  - The loader registers it together with its k-derived indices. In cycle k+3: buf_we=1, buf_data=word k, buf_depth=k[3:2], buf_i=k[1:0].
  - buf_we is therefore high for cycles 3..18 continuously. No bubbles; no write-data combinational path from memory.
  - FETCH→DRAIN after issuing k=15 (end of cycle 16).
  - DRAIN→READY after the write of k=15 (end of cycle 18).
  - READY entered at cycle 19: done=1 in cycle 19 only; buf_re=1 from cycle 19 onward.
- READY exit:
  - consume=1 → IDLE next cycle, buf_re=0.
  - start=1 → FETCH with new base_addr, buf_re=0 next cycle.
  - start and consume both high: start wins (reload).
- Ignored inputs:
  - start is ignored while busy.
  - consume is ignored outside READY.
- Outside write cycles: buf_we=0; buf_data/buf_i/buf_depth hold their last values.
- Outside FETCH: mem_re=0; mem_addr holds its last value.
- Total load latency, start edge to done: 19 cycles.

Test Plan:
- Reset then start with base_addr=0x10, memory word n = {4{n[7:0]}}:
  - mem_addr 0x10..0x1F in cycles 1..16.
  - buf_we cycles 3..18; the write at cycle 3+k carries data {4{0x10+k}}, depth=k>>2, i=k&3.
  - done pulses in cycle 19; buf_re=1 thereafter.
  - With a real layer2_filter_buf attached, data_out[511:504]=0x10 and [7:0]=0x1F.
- base_addr=0xF8 (ADDR_W=8) → addresses F8..FF then 00..07; writes ordered k=0..15 with no gap.
- Second start pulse in cycle 5 of a load → ignored; total still exactly 16 reads, done still in cycle 19.
- In READY, assert consume for 1 cycle → buf_re=0 next cycle, state IDLE.
- In READY, assert start and consume together with base 0x40 → reload from 0x40; done 19 cycles later.
- Assert rst asynchronously mid-FETCH (cycle 7, between edges) → mem_re, buf_we, busy go 0 immediately. A later start performs a full fresh 16-word load.
